// File: rtl/pal_053326_d21_decoder_pkg.sv
// Shared decode map for the Aliens 053326-D21 address decoder: input/output bit
// positions, region match values and the all-deselected output pattern.
package d21_pkg;

  localparam int IDX_AS_N = 9;
  localparam int IDX_BK4  = 8;
  localparam int IDX_INIT = 7;
  localparam int IDX_MAF  = 6;
  localparam int IDX_MAE  = 5;
  localparam int IDX_MAD  = 4;
  localparam int IDX_MAC  = 3;
  localparam int IDX_MAB  = 2;
  localparam int IDX_MAA  = 1;
  localparam int IDX_WOCO = 0;

  localparam int OUT_D20_8   = 7;
  localparam int OUT_WORK    = 6;
  localparam int OUT_BANK    = 5;
  localparam int OUT_D20_13  = 4;
  localparam int OUT_D20_16  = 3;
  localparam int OUT_D18_5   = 2;
  localparam int OUT_PROG    = 1;
  localparam int OUT_C19_1   = 0;

  localparam logic       REG_PROG  = 1'b1;
  localparam logic [2:0] REG_BANK  = 3'b001;
  localparam logic [2:0] REG_WORK  = 3'b000;
  localparam logic [1:0] REG_VIDEO = 2'b01;
  localparam logic [5:0] PAL_BLOCK = 6'b000000;

  localparam logic [7:0] OUT_IDLE = 8'hFF;

endpackage

// File: rtl/pal_053326_d21_decoder_decode_core.sv
// Combinational decode of strobe, A15..A10, BK4, INIT and WOCO into eight
// active-low chip selects; no state.
module d21_decode_core
  import d21_pkg::*;
(
  input  logic [9:0] in,
  output logic [7:0] out_n
);

  logic       act;
  logic [5:0] a;
  logic       t_prog, t_bank, t_pal, t_work, t_video;

  assign act = ~in[IDX_AS_N];
  assign a   = in[IDX_MAF:IDX_MAA];

  assign t_prog  = act && (a[5] == REG_PROG);
  assign t_bank  = act && (a[5:3] == REG_BANK);
  assign t_pal   = act && (a == PAL_BLOCK) && in[IDX_WOCO];
  // Palette steals the bottom 1 KiB of the work RAM page when WOCO is set.
  assign t_work  = act && (a[5:3] == REG_WORK) && !t_pal;
  assign t_video = act && (a[5:4] == REG_VIDEO);

  always_comb begin
    out_n              = OUT_IDLE;
    out_n[OUT_PROG]    = ~t_prog;
    out_n[OUT_BANK]    = ~t_bank;
    out_n[OUT_D18_5]   = ~(t_bank && !in[IDX_BK4]);
    out_n[OUT_D20_8]   = ~(t_bank && in[IDX_BK4]);
    out_n[OUT_D20_16]  = ~t_pal;
    out_n[OUT_WORK]    = ~t_work;
    out_n[OUT_D20_13]  = ~(t_video && !in[IDX_INIT]);
    out_n[OUT_C19_1]   = ~(t_video && in[IDX_INIT]);
  end

endmodule

// File: rtl/pal_053326_d21_decoder.sv
// PAL 053326-D21 replacement: registered active-low selects, 1-cycle latency.
// Define D21_COMB_OUT_EN for zero-latency combinational outputs gated by rst.
module pal_053326_d21_decoder
  import d21_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] in,
  output logic [7:0] out
);

  logic [7:0] dec_n;

  d21_decode_core u_core (
    .in    (in),
    .out_n (dec_n)
  );

`ifdef D21_COMB_OUT_EN
  logic unused_clk;
  assign unused_clk = clk;
  assign out = rst ? OUT_IDLE : dec_n;
`else
  always_ff @(posedge clk) begin
    if (rst) out <= OUT_IDLE;
    else     out <= dec_n;
  end
`endif

endmodule

// File: tb/tb_pal_053326_d21_decoder.sv
// Self-checking bench for the D21 decoder: directed map points, reset, randomized
// back-to-back traffic and an exhaustive sweep against an address-range model.
module tb_pal_053326_d21_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] in;
  logic [7:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  pal_053326_d21_decoder dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  always #5 clk = ~clk;

  // Model works on the real 16-bit CPU address ranges, not on bit patterns.
  function automatic logic [7:0] ref_out(input logic [9:0] v);
    int unsigned addr;
    logic [7:0] r;
    r = 8'hFF;
    if (v[9]) return r;
    addr = int'(v[6:1]) * 1024;
    if (addr >= 32'h8000) begin
      r[1] = 1'b0;
    end else if (addr >= 32'h4000) begin
      if (v[7]) r[0] = 1'b0;
      else      r[4] = 1'b0;
    end else if (addr >= 32'h2000) begin
      r[5] = 1'b0;
      if (v[8]) r[7] = 1'b0;
      else      r[2] = 1'b0;
    end else begin
      if (addr < 32'h0400 && v[0]) r[3] = 1'b0;
      else                         r[6] = 1'b0;
    end
    return r;
  endfunction

  task automatic step_apply(input logic [9:0] v);
    in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in  = 10'h040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 8'hFF) $display("FAIL reset_state: out=%h expected=%h", out, 8'hFF);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_strobe_off;
    logic [9:0] pats [2];
    pats[0] = 10'h200;
    pats[1] = 10'h3FF;
    foreach (pats[i]) begin
      step_apply(pats[i]);
      n_checks++;
      if (out !== 8'hFF) $display("FAIL strobe_off in=%h: out=%h expected=%h", pats[i], out, 8'hFF);
      else n_pass++;
    end
  endtask

  task automatic test_directed;
    logic [9:0] ins  [8];
    logic [7:0] exps [8];
    ins[0] = 10'h040; exps[0] = 8'hFD;
    ins[1] = 10'h000; exps[1] = 8'hBF;
    ins[2] = 10'h001; exps[2] = 8'hF7;
    ins[3] = 10'h005; exps[3] = 8'hBF;
    ins[4] = 10'h010; exps[4] = 8'hDB;
    ins[5] = 10'h110; exps[5] = 8'h5F;
    ins[6] = 10'h020; exps[6] = 8'hEF;
    ins[7] = 10'h0A0; exps[7] = 8'hFE;
    foreach (ins[i]) begin
      step_apply(ins[i]);
      n_checks++;
      if (out !== exps[i]) $display("FAIL directed in=%h: out=%h expected=%h", ins[i], out, exps[i]);
      else n_pass++;
    end
  endtask

  task automatic test_latency;
    // Change input mid-cycle: registered output must still show the old value.
    step_apply(10'h000);
    in = 10'h040;
    #2;
`ifndef D21_COMB_OUT_EN
    n_checks++;
    if (out !== 8'hBF) $display("FAIL latency_hold: out=%h expected=%h", out, 8'hBF);
    else n_pass++;
`endif
    @(posedge clk); #1;
    n_checks++;
    if (out !== 8'hFD) $display("FAIL latency_update: out=%h expected=%h", out, 8'hFD);
    else n_pass++;
  endtask

  task automatic test_reset_pulse;
    step_apply(10'h040);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 8'hFF) $display("FAIL reset_pulse_edge: out=%h expected=%h", out, 8'hFF);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 8'hFD) $display("FAIL reset_pulse_after: out=%h expected=%h", out, 8'hFD);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [9:0] v;
    logic [7:0] e;
    for (int i = 0; i < 300; i++) begin
      v = 10'($urandom_range(0, 1023));
      e = ref_out(v);
      step_apply(v);
      n_checks++;
      if (out !== e) $display("FAIL random in=%h: out=%h expected=%h", v, out, e);
      else n_pass++;
    end
  endtask

  task automatic test_sweep;
    logic [9:0] v;
    logic [7:0] e;
    logic [7:0] low;
    int zeros;
    bit legal;
    for (int i = 0; i < 1024; i++) begin
      v = 10'(i);
      e = ref_out(v);
      step_apply(v);
      n_checks++;
      if (out !== e) $display("FAIL sweep in=%h: out=%h expected=%h", v, out, e);
      else n_pass++;
      low   = ~out;
      zeros = $countones(low);
      if (v[9]) legal = (zeros == 0);
      else      legal = (zeros == 1) || (low == 8'hA0) || (low == 8'h24);
      n_checks++;
      if (!legal) $display("FAIL exclusion in=%h: out=%h selects_low=%0d", v, out, zeros);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in  = 10'h200;
    test_reset();
    test_strobe_off();
    test_directed();
    test_latency();
    test_reset_pulse();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
